mul_div_unit: RTL and testbench



---
 rtl/mul_div_unit_if.sv | 26 ++
 rtl/mul_div_unit.sv | 127 ++++++++++++
 tb/tb_mul_div_unit.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Issue/writeback bundle between the execute stage and the multi-cycle mul/div unit.
interface mul_div_unit_if #(
  parameter int dataWidth    = 64,
  parameter int addressWidth = 5
);
  logic                    start;
  logic [1:0]              op;
  logic [dataWidth-1:0]    operand_a;
  logic [dataWidth-1:0]    operand_b;
  logic [addressWidth-1:0] dest_in;
  logic                    busy;
  logic                    done;
  logic [dataWidth-1:0]    result;
  logic [addressWidth-1:0] dest_out;
  logic                    reg_write;

  modport master (
    output start, op, operand_a, operand_b, dest_in,
    input  busy, done, result, dest_out, reg_write
  );

  modport slave (
    input  start, op, operand_a, operand_b, dest_in,
    output busy, done, result, dest_out, reg_write
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MUL/UDIV/SDIV: one shift-add or restoring shift-subtract step per cycle,
// dataWidth steps per operation, result and write strobe registered on completion.
module mul_div_unit #(
  parameter int dataWidth    = 64,
  parameter int addressWidth = 5
) (
  input logic          clock,
  input logic          reset_n,
  mul_div_unit_if.slave bus
);
  localparam int W  = dataWidth;
  localparam int CW = $clog2(dataWidth) + 1;
  localparam logic [CW-1:0] LAST = CW'(dataWidth - 1);

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_SDIV = 2'b10;
  localparam logic [1:0] OP_RSV  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  st;
  logic [CW-1:0]           cnt;
  logic                    is_mul, neg_q;
  logic [W-1:0]            acc;   // MUL: partial product; DIV: partial remainder
  logic [W-1:0]            x;     // MUL: shifted multiplicand; DIV: dividend/quotient
  logic [W-1:0]            y;     // MUL: shifted multiplier; DIV: divisor
  logic [addressWidth-1:0] dest_q;

  logic [W-1:0] acc_nx, x_nx, y_nx, fin, a_abs, b_abs;
  logic [W:0]   rem_sh, diff;
  logic         is_sdiv, div_zero;

  // SDIV works on magnitudes; MUL and UDIV pass operands through untouched.
  always_comb begin
    is_sdiv  = (bus.op == OP_SDIV);
    a_abs    = (is_sdiv && bus.operand_a[W-1]) ? -bus.operand_a : bus.operand_a;
    b_abs    = (is_sdiv && bus.operand_b[W-1]) ? -bus.operand_b : bus.operand_b;
    div_zero = (bus.op != OP_MUL) && (bus.operand_b == '0);
  end

  always_comb begin
    acc_nx = acc;
    x_nx   = x;
    y_nx   = y;
    rem_sh = '0;
    diff   = '0;
    if (is_mul) begin
      if (y[0]) acc_nx = acc + x;
      x_nx = x << 1;
      y_nx = y >> 1;
    end else begin
      rem_sh = {1'b0, acc, x[W-1]};
      rem_sh = rem_sh[W:0];
      rem_sh = {acc, x[W-1]};
      diff   = rem_sh - {1'b0, y};
      if (rem_sh >= {1'b0, y}) begin
        acc_nx = diff[W-1:0];
        x_nx   = {x[W-2:0], 1'b1};
      end else begin
        acc_nx = rem_sh[W-1:0];
        x_nx   = {x[W-2:0], 1'b0};
      end
    end
    fin = is_mul ? acc_nx : (neg_q ? -x_nx : x_nx);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st            <= IDLE;
      cnt           <= '0;
      is_mul        <= 1'b0;
      neg_q         <= 1'b0;
      acc           <= '0;
      x             <= '0;
      y             <= '0;
      dest_q        <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.reg_write <= 1'b0;
      bus.result    <= '0;
      bus.dest_out  <= '0;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          is_mul   <= (bus.op == OP_MUL);
          neg_q    <= is_sdiv && (bus.operand_a[W-1] ^ bus.operand_b[W-1]);
          acc      <= '0;
          x        <= a_abs;
          y        <= b_abs;
          dest_q   <= bus.dest_in;
          cnt      <= '0;
          bus.busy <= 1'b1;
          // Divide-by-zero and the reserved op short-circuit straight to DONE with 0.
          if (bus.op == OP_RSV || div_zero) begin
            st            <= DONE;
            bus.done      <= 1'b1;
            bus.reg_write <= (bus.op != OP_RSV);
            bus.result    <= '0;
            bus.dest_out  <= bus.dest_in;
          end else begin
            st <= RUN;
          end
        end
        RUN: begin
          acc <= acc_nx;
          x   <= x_nx;
          y   <= y_nx;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            st            <= DONE;
            bus.done      <= 1'b1;
            bus.reg_write <= 1'b1;
            bus.result    <= fin;
            bus.dest_out  <= dest_q;
          end
        end
        DONE: begin
          st            <= IDLE;
          bus.busy      <= 1'b0;
          bus.done      <= 1'b0;
          bus.reg_write <= 1'b0;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized + directed check of mul_div_unit against a plain-arithmetic reference.
module tb_mul_div_unit;
  localparam int W = 64;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  mul_div_unit_if #(.dataWidth(W), .addressWidth(5)) bus ();

  mul_div_unit #(.dataWidth(W), .addressWidth(5)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] r, output logic w, output int lat);
    logic [63:0] ma, mb, q;
    w   = 1'b1;
    lat = W + 1;
    case (o)
      2'b00: r = a * b;
      2'b01: begin
        if (b == 0) begin r = 0; lat = 1; end
        else r = a / b;
      end
      2'b10: begin
        if (b == 0) begin r = 0; lat = 1; end
        else begin
          ma = a[63] ? -a : a;
          mb = b[63] ? -b : b;
          q  = ma / mb;
          r  = (a[63] ^ b[63]) ? -q : q;
        end
      end
      default: begin r = 0; w = 1'b0; lat = 1; end
    endcase
  endfunction

  // Issue one op, scramble inputs after acceptance, then check latency and writeback.
  task automatic issue(input string tag, input logic [1:0] o, input logic [63:0] a,
                       input logic [63:0] b, input logic [4:0] d);
    logic [63:0] er;
    logic        ew;
    int          el, n;
    model(o, a, b, er, ew, el);
    @(negedge clock);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.dest_in = d;
    n = 0;
    do begin
      @(posedge clock); #1; n++;
      if (n == 1) begin
        bus.start     = 1'b0;
        bus.op        = 2'($urandom);
        bus.operand_a = {$urandom, $urandom};
        bus.operand_b = {$urandom, $urandom};
        bus.dest_in   = 5'($urandom);
      end
    end while (!bus.done && n < 200);
    chk({tag, ".lat"}, 64'(n), 64'(el));
    chk({tag, ".res"}, bus.result, er);
    chk({tag, ".wr"}, 64'(bus.reg_write), 64'(ew));
    if (ew) chk({tag, ".dst"}, 64'(bus.dest_out), 64'(d));
    chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
    @(posedge clock); #1;
    chk({tag, ".done1"}, 64'({bus.done, bus.reg_write, bus.busy}), 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [1:0]  ro;
    int          n;
    bus.start = 1'b0; bus.op = '0; bus.operand_a = '0; bus.operand_b = '0; bus.dest_in = '0;

    #12;
    chk("rst.outs", {bus.result[59:0], bus.busy, bus.done, bus.reg_write, 1'b0}, 64'd0);
    chk("rst.dst", 64'(bus.dest_out), 64'd0);
    @(negedge clock); reset_n = 1'b1;

    issue("mul_neg", 2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd9);
    issue("udiv1", 2'b01, 64'd100, 64'd7, 5'd3);
    issue("udiv2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd4);
    issue("sdiv_nn", 2'b10, -64'sd100, 64'd7, 5'd5);
    issue("sdiv_pn", 2'b10, 64'd100, -64'sd7, 5'd6);
    issue("sdiv_mm", 2'b10, -64'sd100, -64'sd7, 5'd7);
    issue("sdiv_min", 2'b10, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8);
    issue("udiv0", 2'b01, 64'd55, 64'd0, 5'd10);
    issue("sdiv0", 2'b10, -64'sd55, 64'd0, 5'd11);
    issue("rsv", 2'b11, 64'd1, 64'd2, 5'd12);

    // Start held high through RUN/DONE with different operands.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 64'd3; bus.operand_b = 64'd5; bus.dest_in = 5'd1;
    @(posedge clock); #1;
    bus.operand_a = 64'd11; bus.operand_b = 64'd13; bus.dest_in = 5'd2;
    n = 1;
    while (!bus.done && n < 200) begin @(posedge clock); #1; n++; end
    chk("hold.lat", 64'(n), 64'd65);
    chk("hold.res", bus.result, 64'd15);
    chk("hold.dst", 64'(bus.dest_out), 64'd1);
    @(posedge clock); #1;
    chk("hold.idle", 64'(bus.busy), 64'd0);
    n = 1;
    while (!bus.done && n < 200) begin @(posedge clock); #1; n++; end
    bus.start = 1'b0;
    chk("b2b.gap", 64'(n), 64'd66);
    chk("b2b.res", bus.result, 64'd143);
    chk("b2b.dst", 64'(bus.dest_out), 64'd2);
    @(posedge clock); @(posedge clock); #1;
    chk("b2b.stop", 64'(bus.busy), 64'd0);

    // Asynchronous reset mid-UDIV.
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 64'd1000; bus.operand_b = 64'd3; bus.dest_in = 5'd20;
    @(posedge clock); #1; bus.start = 1'b0;
    repeat (19) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.res", bus.result, 64'd0);
    chk("arst.flags", 64'({bus.busy, bus.done, bus.reg_write}), 64'd0);
    chk("arst.dst", 64'(bus.dest_out), 64'd0);
    @(negedge clock); @(negedge clock); reset_n = 1'b1;
    n = 0;
    repeat (80) begin @(posedge clock); #1; if (bus.done) n++; end
    chk("arst.nodone", 64'(n), 64'd0);
    issue("post_rst", 2'b01, 64'd9, 64'd3, 5'd21);

    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 2));
      if (i % 11 == 10) ro = 2'b11;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      case (i % 4)
        1: rb = 64'($urandom_range(1, 1000));
        2: if (i % 8 == 2) rb = 64'd0; else rb = -64'($urandom_range(1, 50));
        3: ra = {32'd0, $urandom};
        default: ;
      endcase
      issue($sformatf("rnd%0d", i), ro, ra, rb, 5'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
